// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment codes, digit count and converter state encoding.
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative 16-bit to 5-nibble double-dabble, 16 steps plus one commit cycle.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);
  state_t state, state_n;
  logic [15:0] sr;
  logic [19:0] acc, adj;
  logic [3:0] step;
  for (genvar i = 0; i < 5; i++) begin : g_adj
    assign adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (start ? CONV : IDLE) :
              state == CONV ? (step == 4'd15 ? DONE : CONV) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      acc <= '0;
      step <= '0;
    end else if (state == IDLE && start) begin
      sr <= bin;
      acc <= '0;
      step <= '0;
    end else if (state == CONV) begin
      {acc, sr} <= {adj[18:0], sr, 1'b0};
      step <= step + 4'd1;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bcd = acc;
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: captures a value, converts it to BCD and scans it onto a 4-digit 7-segment display.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit SEG_INV = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic        busy,
  output logic        ovf,
  output logic [6:0]  out1,
  output logic        led1,
  output logic        led2,
  output logic        led3,
  output logic        led4
);
  localparam int CW = $clog2(SCAN_DIV);
  logic done;
  logic [19:0] bcd;
  logic [CW-1:0] cnt;
  logic [1:0] idx, idx_n;
  logic [4*NUM_DIGITS-1:0] dig, dig_n;
  logic ovf_r, ovf_n, tc;
  logic [6:0] seg;
  logic [3:0] en;
  bin2bcd_seq u_conv (
    .clk(clk),
    .rst(rst),
    .start(load),
    .bin(value),
    .busy(busy),
    .done(done),
    .bcd(bcd)
  );
  assign tc = cnt == CW'(SCAN_DIV - 1);
  assign idx_n = tc ? idx + 2'd1 : idx;
  assign dig_n = done ? bcd[15:0] : dig;
  assign ovf_n = done ? |bcd[19:16] : ovf_r;
  // Segments and enables are both registered from next-cycle index/digits so they switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      dig <= '0;
      ovf_r <= 1'b0;
      seg <= SEG_0;
      en <= 4'b0001;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      idx <= idx_n;
      dig <= dig_n;
      ovf_r <= ovf_n;
      seg <= ovf_n ? SEG_DASH : seg_code(dig_n[{~idx_n, 2'b00} +: 4]);
      en <= 4'b0001 << idx_n;
    end
  end
  assign ovf = ovf_r;
  assign out1 = SEG_INV ? ~seg : seg;
  assign {led4, led3, led2, led1} = SEG_INV ? ~en : en;
endmodule
